// File: rtl/riscv_core_pkg.sv
// Shared core definitions: data width, canonical NOP, default reset PC and the fetch FSM states.
package riscv_core_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP_INSN         = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH_REQ  = 2'd0,
      FETCH_WAIT = 2'd1,
      FETCH_HOLD = 2'd2
   } fetch_state_e;

   // Instruction addresses are word aligned; the low two bits are simply dropped.
   function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] pc);
      return {pc[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and memory (slave).
interface if_fetch_unit_if;
   import riscv_core_pkg::*;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_gnt;
   logic            imem_rvalid;
   logic [XLEN-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );

endinterface

// File: rtl/if_fetch_unit_perf_counters.sv
// Fetch statistics: delivered instructions and bubble cycles; only built with FETCH_PERF_CNT_EN.
module if_perf_counters (
   input  logic        clk,
   input  logic        rst,
   input  logic        insn_valid_i,
   input  logic        stall_i,
   input  logic        redirect_valid_i,
   output logic [31:0] fetch_cnt_o,
   output logic [31:0] bubble_cnt_o
);

   logic [31:0] fetchCnt_q, fetchCnt_d;
   logic [31:0] bubbleCnt_q, bubbleCnt_d;

   always_comb begin
      fetchCnt_d  = fetchCnt_q;
      bubbleCnt_d = bubbleCnt_q;
      if (insn_valid_i && !stall_i && !redirect_valid_i) begin
         fetchCnt_d = fetchCnt_q + 32'd1;
      end
      if (!insn_valid_i || stall_i) begin
         bubbleCnt_d = bubbleCnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetchCnt_q  <= '0;
         bubbleCnt_q <= '0;
      end else begin
         fetchCnt_q  <= fetchCnt_d;
         bubbleCnt_q <= bubbleCnt_d;
      end
   end

   assign fetch_cnt_o  = fetchCnt_q;
   assign bubble_cnt_o = bubbleCnt_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem requests, redirect/stall/squash handling.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module if_fetch_unit
   import riscv_core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   if_fetch_unit_if.master imem,
   output logic            insn_valid,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] insn_out
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]     fetch_cnt,
   output logic [31:0]     bubble_cnt
`endif
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pcReg_q, pcReg_d;
   logic [XLEN-1:0] reqPc_q, reqPc_d;
   logic [XLEN-1:0] holdInsn_q, holdInsn_d;
   logic            kill_q, kill_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= FETCH_REQ;
         pcReg_q    <= RESET_PC;
         reqPc_q    <= '0;
         holdInsn_q <= NOP_INSN;
         kill_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pcReg_q    <= pcReg_d;
         reqPc_q    <= reqPc_d;
         holdInsn_q <= holdInsn_d;
         kill_q     <= kill_d;
      end
   end

   // A redirect while a response is still in flight arms kill so that response is discarded.
   always_comb begin
      state_d    = state_q;
      pcReg_d    = pcReg_q;
      reqPc_d    = reqPc_q;
      holdInsn_d = holdInsn_q;
      kill_d     = kill_q;
      case (state_q)
         FETCH_REQ: begin
            if (imem.imem_gnt) begin
               reqPc_d = pcReg_q;
               pcReg_d = pcReg_q + 32'd4;
               kill_d  = redirect_valid;
               state_d = FETCH_WAIT;
            end
         end
         FETCH_WAIT: begin
            if (imem.imem_rvalid) begin
               kill_d = 1'b0;
               if (!redirect_valid && !kill_q && stall) begin
                  holdInsn_d = imem.imem_rdata;
                  state_d    = FETCH_HOLD;
               end else begin
                  state_d = FETCH_REQ;
               end
            end else if (redirect_valid) begin
               kill_d = 1'b1;
            end
         end
         FETCH_HOLD: begin
            if (redirect_valid || !stall) begin
               state_d = FETCH_REQ;
            end
         end
         default: begin
            state_d = FETCH_REQ;
         end
      endcase
      if (redirect_valid) begin
         pcReg_d = alignPc(redirect_pc);
      end
   end

   // imem_req depends only on registered state so stall/redirect never reach it combinationally.
   always_comb begin
      imem.imem_req  = 1'b0;
      imem.imem_addr = RESET_PC;
      insn_valid     = 1'b0;
      pc_out         = '0;
      insn_out       = NOP_INSN;
      if (rst) begin
         case (state_q)
            FETCH_REQ: begin
               imem.imem_req  = 1'b1;
               imem.imem_addr = pcReg_q;
            end
            FETCH_WAIT: begin
               imem.imem_addr = reqPc_q;
               if (imem.imem_rvalid && !kill_q && !redirect_valid) begin
                  insn_valid = 1'b1;
                  pc_out     = reqPc_q;
                  insn_out   = imem.imem_rdata;
               end
            end
            FETCH_HOLD: begin
               imem.imem_addr = reqPc_q;
               if (!redirect_valid) begin
                  insn_valid = 1'b1;
                  pc_out     = reqPc_q;
                  insn_out   = holdInsn_q;
               end
            end
            default: begin
               imem.imem_addr = pcReg_q;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   if_perf_counters uPerfCounters (
      .clk              (clk),
      .rst              (rst),
      .insn_valid_i     (insn_valid),
      .stall_i          (stall),
      .redirect_valid_i (redirect_valid),
      .fetch_cnt_o      (fetch_cnt),
      .bubble_cnt_o     (bubble_cnt)
   );
`endif

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the five-stage RISC-V core: owns the program counter, issues single-outstanding requests to instruction memory, and drives the pc/instruction pair that the IF/ID pipeline latch captures. It handles redirects from EX (branch/jump), hazard-unit stalls and in-flight response squashing. Empty slots are presented to IF/ID as a canonical NOP.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSN, 32'h0000_0013, instruction presented when no valid fetch (addi x0,x0,0)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- stall  in  1  hazard unit: IF/ID not accepting this cycle (IF/ID en = !stall)
- redirect_valid  in  1  EX requests PC change
- redirect_pc  in  32  new PC; bits [1:0] ignored (treated as 00)
- imem_req  out  1  request valid
- imem_addr  out  32  request word address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid (earliest cycle after gnt)
- imem_rdata  in  32  response instruction
- insn_valid  out  1  pc_out/insn_out hold a real instruction
- pc_out  out  32  PC of presented instruction
- insn_out  out  32  presented instruction, NOP_INSN when !insn_valid

## Operation
- State register {REQ, WAIT, HOLD}; registers pc_reg, req_pc, hold_insn, kill.
- Reset: state=REQ, pc_reg=RESET_PC, kill=0. Outputs during reset cycle: imem_req=0, imem_addr=RESET_PC, insn_valid=0, pc_out=0, insn_out=NOP_INSN.
- REQ: imem_req=1, imem_addr=pc_reg. On gnt: req_pc<=pc_reg, pc_reg<=pc_reg+4 (mod 2^32, wraps), ->WAIT. imem_rvalid ignored in REQ.
- WAIT: imem_req=0. On rvalid with kill=0: insn_valid=1, pc_out=req_pc, insn_out=imem_rdata (combinational); !stall ->REQ; stall -> hold_insn<=rdata, ->HOLD. On rvalid with kill=1: discard, kill<=0, ->REQ.
- HOLD: insn_valid=1, pc_out=req_pc, insn_out=hold_insn; remain until !stall, then ->REQ.
- Redirect (highest priority, any state): pc_reg<=redirect_pc&~3; insn_valid forced 0 that cycle.
  - REQ without gnt: stay REQ, new address next cycle (address may change only before gnt).
  - REQ with gnt: ->WAIT, kill<=1.
  - WAIT without rvalid: kill<=1, stay WAIT.
  - WAIT with rvalid, or HOLD: instruction dropped, kill<=0, ->REQ.
- Stall alone never drops an instruction and never changes pc_reg.
- Synchronous reset mid-transaction abandons outstanding response; memory is reset by the same rst.

## Timing
- Zero-wait memory (gnt in REQ, rvalid next cycle): one instruction per 2 cycles; insn_valid 1 cycle after gnt.
- First fetch: imem_req=1 in first cycle after rst deasserts.
- Redirect to insn_valid of target: minimum 2 cycles (REQ, WAIT) when no kill pending.
- imem_addr stable from gnt until next REQ.
- No combinational path from stall/redirect to imem_req.

## Configuration
- FETCH_PERF_CNT_EN defined: adds outputs fetch_cnt[31:0] (increments on each insn_valid && !stall && !redirect_valid) and bubble_cnt[31:0] (increments each cycle insn_valid=0 or stall=1); both reset to 0, wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Shared package riscv_core_pkg: fetch state enum, NOP_INSN constant, default RESET_PC, XLEN=32.
- Sub-module if_perf_counters (instantiated only under FETCH_PERF_CNT_EN); FSM and datapath stay in if_fetch_unit.

## Test plan
- Reset release, zero-wait memory returning addr as data -> imem_addr 0,4,8; insn_valid every 2nd cycle with pc_out 0,4,8; insn_out=NOP_INSN between.
- Stall held 3 cycles while insn at pc 8 valid -> HOLD; pc_out=8, insn_out stable; next fetch imem_addr=12 only after stall drops.
- Redirect to 0x100 in WAIT before rvalid (rvalid 2 cycles later, data 0xDEAD) -> 0xDEAD never valid; next request imem_addr=0x100.
- Redirect to 0x203 in same cycle as gnt -> response killed; next imem_addr=0x200.
- pc_reg=0xFFFF_FFFC fetched -> next imem_addr=0x0000_0000.
- rst asserted in WAIT, late rvalid in first REQ cycle -> ignored, imem_addr=RESET_PC, insn_valid=0; with FETCH_PERF_CNT_EN counters read 0.
